apu_frame_counter: RTL and testbench

//  APU frame sequencer ($4017) driving quarter/half-frame clocks into the channel blocks
//  (triangle linear/length counters, envelopes, sweeps). Also drives the APU half-rate clock
//  (apuclk) and the frame IRQ. It sits upstream of every channel and counts sys.clk (CPU) cycles.

---
 rtl/apu_frame_counter.sv | 105 ++++++++++
 tb/tb_apu_frame_counter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_frame_counter.sv
// APU frame sequencer ($4017): quarter/half-frame strobes, half-rate apuclk and frame IRQ.
// Counts CPU clocks; a $4017 write resets the sequence after a 3/4-clock phase-dependent delay.
module apu_frame_counter #(
    parameter logic [15:0] STEP1       = 16'd7457,
    parameter logic [15:0] STEP2       = 16'd14913,
    parameter logic [15:0] STEP3       = 16'd22371,
    parameter logic [15:0] STEP4       = 16'd29829,
    parameter logic [15:0] STEP5       = 16'd37281,
    parameter logic [2:0]  WR_DLY_EVEN = 3'd3,
    parameter logic [2:0]  WR_DLY_ODD  = 3'd4
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       we,
    input  logic [7:6] data,
    input  logic       sel,
    input  logic       irq_clr,
    output logic       apuclk,
    output logic       qframe,
    output logic       hframe,
    output logic       irq
);

    typedef enum logic {
        SEQ_RUN,
        SEQ_PENDING
    } seq_state_t;

    seq_state_t  state;
    logic [15:0] cyc;
    logic [2:0]  dly;
    logic        mode;
    logic        inhibit;
    logic        wrapped;

    logic wr;
    logic dly_done;
    logic final_hit;
    logic q_fire;
    logic h_fire;
    logic irq_set;

    always_comb begin
        wr        = sel & we;
        // a write landing on the expiry cycle reloads the delay instead of resetting
        dly_done  = (state == SEQ_PENDING) && (dly == 3'd1) && !wr;
        final_hit = mode ? (cyc == STEP5) : (cyc == STEP4);
        q_fire    = (cyc == STEP1) || (cyc == STEP2) || (cyc == STEP3) || final_hit
                    || (dly_done && mode);
        h_fire    = (cyc == STEP2) || final_hit || (dly_done && mode);
        irq_set   = !mode && !inhibit
                    && ((cyc == STEP4 - 16'd1) || (cyc == STEP4) || ((cyc == '0) && wrapped));
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= SEQ_RUN;
            cyc     <= '0;
            dly     <= '0;
            mode    <= 1'b0;
            inhibit <= 1'b0;
            wrapped <= 1'b0;
            apuclk  <= 1'b0;
            qframe  <= 1'b0;
            hframe  <= 1'b0;
            irq     <= 1'b0;
        end else begin
            apuclk  <= ~apuclk;
            // suppressing a strobe that directly follows another keeps them non-adjacent
            qframe  <= q_fire && !qframe;
            hframe  <= h_fire && !hframe;
            wrapped <= 1'b0;

            if (dly_done) begin
                cyc <= '0;
            end else if (final_hit) begin
                cyc     <= '0;
                wrapped <= !mode;
            end else begin
                cyc <= cyc + 16'd1;
            end

            if (wr) begin
                mode    <= data[7];
                inhibit <= data[6];
                dly     <= apuclk ? WR_DLY_ODD : WR_DLY_EVEN;
                state   <= SEQ_PENDING;
            end else if (state == SEQ_PENDING) begin
                dly <= dly - 3'd1;
                if (dly_done) begin
                    state <= SEQ_RUN;
                end
            end

            if (wr && data[6]) begin
                irq <= 1'b0;
            end else if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apu_frame_counter.sv
// Bench for apu_frame_counter with shortened step constants; strobe timing is scored
// against a queue of expected events, IRQ and write behaviour against a vector table.
module tb_apu_frame_counter;

    localparam int S1 = 20;
    localparam int S2 = 40;
    localparam int S3 = 60;
    localparam int S4 = 80;
    localparam int S5 = 100;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       we = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] data = '0;
    logic       irq_clr = 1'b0;
    logic       apuclk;
    logic       qframe;
    logic       hframe;
    logic       irq;

    apu_frame_counter #(
        .STEP1(16'(S1)),
        .STEP2(16'(S2)),
        .STEP3(16'(S3)),
        .STEP4(16'(S4)),
        .STEP5(16'(S5))
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .we     (we),
        .data   (data[7:6]),
        .sel    (sel),
        .irq_clr(irq_clr),
        .apuclk (apuclk),
        .qframe (qframe),
        .hframe (hframe),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_chk = 0;
    int n_pass = 0;
    int rbase = 0;
    bit started = 1'b0;

    typedef struct {
        int at;
        bit q;
        bit h;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        string      name;
        logic [7:0] wdata;
        bit         ph;
        int         gap;
        int         dly;
        bit         irq_pre;
        bit         irq_w;
    } wr_vec_t;
    wr_vec_t tab[5];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    endtask

    // Expected strobes for n periods of a sequence whose cyc is 0 after edge base.
    task automatic push_period(input int base, input bit m, input int n);
        int per;
        per = m ? S5 + 1 : S4 + 1;
        for (int p = 0; p < n; p++) begin
            sb.push_back('{base + p * per + S1 + 1, 1'b1, 1'b0});
            sb.push_back('{base + p * per + S2 + 1, 1'b1, 1'b1});
            sb.push_back('{base + p * per + S3 + 1, 1'b1, 1'b0});
            sb.push_back('{base + p * per + (m ? S5 : S4) + 1, 1'b1, 1'b1});
        end
    endtask

    task automatic sched_reset(input int r, input bit m);
        while (sb.size() > 0 && sb[$].at >= r) void'(sb.pop_back());
        if (m) sb.push_back('{r, 1'b1, 1'b1});
        push_period(r, m, 2);
    endtask

    function automatic bit phase_now();
        return bit'((edge_n - rbase) & 1);
    endfunction

    task automatic wait_to(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    task automatic goto(input int e, input bit ph);
        while (edge_n < e || phase_now() != ph) @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] d, output int w);
        sel  = 1'b1;
        we   = 1'b1;
        data = d;
        @(negedge clk);
        sel = 1'b0;
        we  = 1'b0;
        w   = edge_n;
    endtask

    task automatic do_write2(input logic [7:0] d1, input logic [7:0] d2, output int w2);
        sel  = 1'b1;
        we   = 1'b1;
        data = d1;
        @(negedge clk);
        data = d2;
        @(negedge clk);
        sel = 1'b0;
        we  = 1'b0;
        w2  = edge_n;
    endtask

    // Scoreboard: every strobe must match the head of the queue on its exact edge.
    always @(negedge clk) begin
        if (n_reset && started) begin
            while (sb.size() > 0 && sb[0].at < edge_n) begin
                check("strobe_stale", 0, 1);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].at == edge_n) begin
                check("qframe", int'(qframe), int'(sb[0].q));
                check("hframe", int'(hframe), int'(sb[0].h));
                void'(sb.pop_front());
            end else if (qframe || hframe) begin
                check("unexpected_strobe", int'({qframe, hframe}), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, r;
        int p0;

        tab[0] = '{"mode1_even",    8'h80, 1'b0, 30,  3, 1'b0, 1'b0};
        tab[1] = '{"mode0_odd",     8'h00, 1'b1, 111, 4, 1'b0, 1'b0};
        tab[2] = '{"inhibit_clr",   8'h40, 1'b0, 86,  3, 1'b1, 1'b0};
        tab[3] = '{"mode1_inh_odd", 8'hC0, 1'b1, 91,  4, 1'b0, 1'b0};
        tab[4] = '{"mode0_even",    8'h00, 1'b0, 30,  3, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_apuclk", int'(apuclk), 0);
        check("rst_qframe", int'(qframe), 0);
        check("rst_hframe", int'(hframe), 0);
        check("rst_irq", int'(irq), 0);

        // Power-on sequence in 4-step mode, IRQ window and irq_clr priority.
        n_reset = 1'b1;
        rbase   = edge_n;
        started = 1'b1;
        push_period(rbase, 1'b0, 2);
        wait_to(rbase + S4 - 1);
        check("irq_before_set", int'(irq), 0);
        check("apuclk_toggle", int'(apuclk), (S4 - 1) & 1);
        wait_to(rbase + S4);
        check("irq_rise", int'(irq), 1);
        irq_clr = 1'b1;
        wait_to(rbase + S4 + 1);
        irq_clr = 1'b0;
        check("irq_set_beats_clr", int'(irq), 1);
        wait_to(rbase + S4 + 2);
        check("irq_third_set", int'(irq), 1);
        wait_to(rbase + S4 + 6);
        check("irq_held", int'(irq), 1);
        irq_clr = 1'b1;
        wait_to(rbase + S4 + 7);
        irq_clr = 1'b0;
        check("irq_clr", int'(irq), 0);

        // Back-to-back writes: even then odd phase -> single reset 4 clocks after the 2nd.
        p0 = rbase + S4 + 1;
        goto(p0 + 30, 1'b0);
        check("b2b1_apuclk", int'(apuclk), 0);
        do_write2(8'h80, 8'h80, w);
        r = w + 4;
        sched_reset(r, 1'b1);
        wait_to(r);
        check("b2b1_irq", int'(irq), 0);

        // Odd then even phase, mode changes to 5-step on the second write.
        goto(r + 30, 1'b1);
        check("b2b2_apuclk", int'(apuclk), 1);
        do_write2(8'h00, 8'h80, w);
        r = w + 3;
        sched_reset(r, 1'b1);

        for (int i = 0; i < 5; i++) begin
            goto(r + tab[i].gap, tab[i].ph);
            check({tab[i].name, "_irq_pre"}, int'(irq), int'(tab[i].irq_pre));
            check({tab[i].name, "_apuclk"}, int'(apuclk), int'(tab[i].ph));
            do_write(tab[i].wdata, w);
            check({tab[i].name, "_irq_w"}, int'(irq), int'(tab[i].irq_w));
            r = w + tab[i].dly;
            sched_reset(r, tab[i].wdata[7]);
        end

        // Reset mid-period and mid-pending with irq set.
        wait_to(r + S4 + 1 + 50);
        check("pre_reset_irq", int'(irq), 1);
        do_write(8'h80, w);
        check("pending_irq", int'(irq), 1);
        n_reset = 1'b0;
        sb.delete();
        #1;
        check("async_qframe", int'(qframe), 0);
        check("async_hframe", int'(hframe), 0);
        check("async_irq", int'(irq), 0);
        check("async_apuclk", int'(apuclk), 0);
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        rbase   = edge_n;
        push_period(rbase, 1'b0, 1);
        wait_to(rbase + S4 - 1);
        check("rerun_irq_before", int'(irq), 0);
        wait_to(rbase + S4);
        check("rerun_irq_rise", int'(irq), 1);
        wait_to(rbase + S4 + 10);
        check("queue_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
